// File: rtl/uart_tx_scheduler_pkg.sv
// ============================================================================
// Module  : uart_ctrl_pkg
// Brief   : Shared types and width helpers for the UART TX scheduler.
// Revision: 1.0
// ============================================================================
`default_nettype none

package uart_ctrl_pkg;

  localparam int C_DEF_DATA_W = 8;
  localparam int C_DEF_N_REQ  = 4;
  localparam int C_DEF_IDX_W  = $clog2(C_DEF_N_REQ);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_GAP       = 2'd3
  } sched_state_t;

  // One counter serves both the gap and the timeout, so size it for the larger.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_scheduler_rr_pick.sv
// ============================================================================
// Module  : rr_pick
// Brief   : Round-robin winner search starting one past the last grant.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_pick
  import uart_ctrl_pkg::*;
#(
  parameter int N_REQ = C_DEF_N_REQ,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_pending,
  input  logic [IDX_W-1:0] i_last_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  logic [IDX_W-1:0] w_cand;

  // Walk from farthest to nearest so the nearest pending source wins last.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_cand = IDX_W'((int'(i_last_grant) + k) % N_REQ);
      if (i_pending[w_cand]) begin
        o_idx   = w_cand;
        o_valid = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
// ============================================================================
// Module  : uart_tx_scheduler
// Brief   : Round-robin sharing of one UART transmitter among N_REQ sources.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_tx_scheduler
  import uart_ctrl_pkg::*;
#(
  parameter int N_REQ          = C_DEF_N_REQ,
  parameter int DATA_W         = C_DEF_DATA_W,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        i_req_pulse,
  input  logic [N_REQ*DATA_W-1:0] i_req_data,
  output logic [N_REQ-1:0]        o_req_ack,
  output logic                    o_tx_start,
  output logic [DATA_W-1:0]       o_tx_data,
  input  logic                    i_tx_busy,
  input  logic                    i_tx_done,
  output logic [$clog2(N_REQ)-1:0] o_grant_id,
  output logic                    o_sched_busy,
  output logic [N_REQ-1:0]        o_overrun,
  output logic                    o_timeout_err,
  input  logic                    i_err_clr
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = cnt_width(GAP_CYCLES, TIMEOUT_CYCLES);

  sched_state_t      r_state;
  logic [N_REQ-1:0]  r_pending;
  logic [DATA_W-1:0] r_hold [N_REQ];
  logic [N_REQ-1:0]  r_overrun;
  logic [IDX_W-1:0]  r_last_grant;
  logic [IDX_W-1:0]  r_grant_id;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_tx_start;
  logic [N_REQ-1:0]  r_req_ack;
  logic              r_timeout_err;

  logic [IDX_W-1:0]  w_pick_idx;
  logic              w_pick_valid;
  logic              w_launch;
  logic [N_REQ-1:0]  w_launch_vec;
  logic              w_timeout;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .i_pending    (r_pending),
    .i_last_grant (r_last_grant),
    .o_idx        (w_pick_idx),
    .o_valid      (w_pick_valid)
  );

  assign w_launch     = (r_state == S_IDLE) && w_pick_valid && !i_tx_busy;
  assign w_launch_vec = w_launch ? (N_REQ'(1) << w_pick_idx) : '0;
  assign w_timeout    = (r_state == S_WAIT_DONE) && !i_tx_done && (r_cnt == CNT_W'(1));

  // A pulse on the launch edge refills the slot being emptied, so it is not an overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_overrun <= '0;
      for (int i = 0; i < N_REQ; i++) r_hold[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (i_req_pulse[i] && (!r_pending[i] || w_launch_vec[i])) begin
          r_pending[i] <= 1'b1;
          r_hold[i]    <= i_req_data[i*DATA_W +: DATA_W];
        end else if (w_launch_vec[i]) begin
          r_pending[i] <= 1'b0;
        end
        if (i_req_pulse[i] && r_pending[i] && !w_launch_vec[i]) r_overrun[i] <= 1'b1;
        else if (i_err_clr)                                     r_overrun[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_last_grant  <= IDX_W'(N_REQ - 1);
      r_grant_id    <= '0;
      r_cnt         <= '0;
      r_tx_data     <= '0;
      r_tx_start    <= 1'b0;
      r_req_ack     <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      r_req_ack  <= '0;
      if (w_timeout)      r_timeout_err <= 1'b1;
      else if (i_err_clr) r_timeout_err <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_tx_data    <= r_hold[w_pick_idx];
            r_grant_id   <= w_pick_idx;
            r_last_grant <= w_pick_idx;
            r_tx_start   <= 1'b1;
            r_req_ack    <= w_launch_vec;
            r_cnt        <= CNT_W'(TIMEOUT_CYCLES);
            r_state      <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_cnt   <= r_cnt - CNT_W'(1);
          r_state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (i_tx_done || w_timeout) begin
            if (GAP_CYCLES == 0) begin
              r_cnt   <= '0;
              r_state <= S_IDLE;
            end else begin
              r_cnt   <= CNT_W'(GAP_CYCLES);
              r_state <= S_GAP;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_GAP: begin
          if (r_cnt == CNT_W'(1)) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_req_ack     = r_req_ack;
  assign o_tx_start    = r_tx_start;
  assign o_tx_data     = r_tx_data;
  assign o_grant_id    = r_grant_id;
  assign o_sched_busy  = (r_state != S_IDLE);
  assign o_overrun     = r_overrun;
  assign o_timeout_err = r_timeout_err;

endmodule

`default_nettype wire
